meshed_network_data_writer: RTL and testbench
=============================================

Name: meshed_network_data_writer

Overview:
- Ingress end of the meshed-network fetcher protocol. The remote chip's fetcher emits an AXI-Stream packet: one header beat carrying destination address and byte length, followed by payload beats.
- This block depacketizes that stream and issues AXI4 write bursts (AW/W/B) into local memory.
- It sits behind the ingress round-robin mux and drives the chip's AXI master write port.

Parameters:
- AddrWidth, 48, AXI address width; header address field width.
- DataWidth, 64, AXIS tdata and AXI wdata width; fixed at 64 in this revision.
- IdWidth, 4, AXI ID width.
- AxiId, 0, constant ID driven on awid.
- MaxBurstBeats, 256, upper limit on beats per AW burst (1..256).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- s_axis_tvalid_i  in  1  ingress stream valid
- s_axis_tready_o  out  1  ingress stream ready
- s_axis_tdata_i  in  DataWidth  header or payload beat
- s_axis_tlast_i  in  1  last beat of packet
- aw_id_o  out  IdWidth  always AxiId
- aw_addr_o  out  AddrWidth  burst start address
- aw_len_o  out  8  beats-1
- aw_size_o  out  3  constant 3 (8 B)
- aw_burst_o  out  2  constant INCR (2'b01)
- aw_valid_o  out  1  address valid
- aw_ready_i  in  1  address ready
- w_data_o  out  DataWidth  payload
- w_strb_o  out  DataWidth/8  all ones
- w_last_o  out  1  last beat of burst
- w_valid_o  out  1  write valid
- w_ready_i  in  1  write ready
- b_resp_i  in  2  write response
- b_valid_i  in  1  response valid
- b_ready_o  out  1  response ready
- busy_o  out  1  high when not in IDLE
- done_o  out  1  one-cycle pulse when a packet completes
- err_o  out  1  sticky error flag
- err_clr_i  in  1  clears err_o

Behaviour:
- Reset: state=IDLE; all valid outputs, b_ready_o, s_axis_tready_o, busy_o, done_o and err_o at 0; counters at 0.
- Header beat:
  - tdata[47:0] = destination byte address.
  - tdata[63:48] = length in bytes.
  - Header is valid iff address[2:0]==0, length!=0 and length[2:0]==0. Total beats = length>>3.
- IDLE:
  - tready=1; on a header handshake, latch address and beats_remaining.
  - Valid header -> AW. Invalid header -> set err; go to IDLE if tlast is set on the header beat, else DRAIN.
- AW:
  - burst_beats = min(beats_remaining, MaxBurstBeats, (4096 - addr[11:0])>>3). Bursts never cross a 4 KiB boundary.
  - Drive aw_valid; aw_len = burst_beats-1. aw_* stay stable until aw_ready. Handshake -> W.
- W:
  - Combinational pass-through: w_valid=tvalid, tready=w_ready, w_data=tdata. Zero latency.
  - w_last asserts when beat_cnt==burst_beats-1.
  - No W beat is issued before its AW is accepted.
  - On the last-beat handshake: addr += burst_beats*8, beats_remaining -= burst_beats, then -> B.
- B:
  - b_ready=1; on b_valid, bresp!=OKAY sets err.
  - Then -> AW if beats_remaining!=0; otherwise done_o pulses for one cycle and -> IDLE.
- Framing:
  - Length governs the packet; tlast is checked, not obeyed.
  - tlast on a non-final payload beat sets err; writing continues.
  - Final payload beat without tlast sets err; -> DRAIN to discard beats up to and including the next tlast.
- DRAIN: tready=1, no AXI activity; on tlast handshake -> IDLE.
- err_o: sticky. err_clr_i clears it; a set in the same cycle wins.
- Reset mid-packet: immediate return to IDLE; any outstanding AXI transaction is abandoned. The system resets interconnect and writer together.

Decomposition:
- Package meshed_network_pkg holds:
  - header field offsets and widths (HdrAddrLsb=0, HdrLenLsb=48, HdrLenWidth=16);
  - BytesPerBeat=8 and the 4 KiB page constant;
  - the FSM state enum;
  - the axis/AXI struct typedefs used when the top level wraps these flat ports.
- Sub-module meshed_network_burst_splitter (combinational): computes burst_beats from addr, beats_remaining and MaxBurstBeats. Unit-testable on its own.

Test Plan:
- Header addr=0x1000, len=64, then 8 beats with tlast on beat 8 -> one AW (addr 0x1000, len 7); 8 W beats, w_last on 8th; done_o pulses after B.
- addr=0x0FF0, len=32 -> two bursts: (0x0FF0, len 1) and (0x1000, len 1); err_o stays 0.
- len=4096 at 0x0 with MaxBurstBeats=256 -> two AWs: (0x0, len 255) and (0x800, len 255).
- Header len=12 followed by 3 beats and tlast -> no AW; err_o=1; tlast consumed; back in IDLE. err_clr_i then clears err_o.
- Random w_ready/aw_ready/tvalid stalls, bresp=SLVERR on the second burst of a 2-burst packet -> data order intact, err_o=1, done_o still pulses.
- rst_i asserted while in W after 3 beats -> all outputs 0 the same cycle; next header is processed normally.

Source files
------------

// File: rtl/meshed_network_pkg.sv
// Shared definitions for the meshed-network data writer.
// Holds the header field layout, beat/page constants, the writer FSM state
// type and the stream/AXI struct views used when flat ports get bundled.
package meshed_network_pkg;

    // Header beat layout
    localparam int unsigned HdrAddrLsb  = 0;
    localparam int unsigned HdrLenLsb   = 48;
    localparam int unsigned HdrLenWidth = 16;

    localparam int unsigned BytesPerBeat = 8;
    localparam int unsigned PageBytes    = 4096;

    // Burst length in beats, 1..256 needs 9 bits
    localparam int unsigned BurstWidth = 9;

    typedef enum logic [2:0] {
        StIdle,
        StAw,
        StW,
        StB,
        StDrain
    } wr_state_e;

    typedef struct packed {
        logic        tvalid;
        logic [63:0] tdata;
        logic        tlast;
    } axis_beat_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [47:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        valid;
    } axi_aw_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
        logic        valid;
    } axi_w_t;

endpackage

// File: rtl/meshed_network_burst_splitter.sv
// Combinational burst sizing for the data writer.
// Ports:
//   page_off_i        - low 12 bits of the current write address
//   beats_remaining_i - payload beats still to be written
//   burst_beats_o     - beats in the next burst: min(remaining, MaxBurstBeats,
//                       beats left before the next 4 KiB boundary)
module meshed_network_burst_splitter
    import meshed_network_pkg::*;
#(
    parameter int unsigned MaxBurstBeats = 256
) (
    input  logic [11:0]            page_off_i,
    input  logic [HdrLenWidth-1:0] beats_remaining_i,
    output logic [BurstWidth-1:0]  burst_beats_o
);

    logic [12:0]            page_bytes;
    logic [HdrLenWidth-1:0] page_beats;
    logic [HdrLenWidth-1:0] max_beats;
    logic [HdrLenWidth-1:0] cand;
    logic [HdrLenWidth-1:0] result;

    always_comb begin
        page_bytes = 13'(PageBytes) - {1'b0, page_off_i};
        page_beats = HdrLenWidth'(page_bytes >> 3);
        max_beats  = HdrLenWidth'(MaxBurstBeats);

        cand   = (beats_remaining_i < max_beats) ? beats_remaining_i : max_beats;
        result = (cand < page_beats) ? cand : page_beats;

        burst_beats_o = BurstWidth'(result);
    end

endmodule

// File: rtl/meshed_network_data_writer.sv
// Ingress depacketizer: turns a header+payload AXI-Stream packet into AXI4
// write bursts (AW/W/B) that never cross a 4 KiB page.
// Ports:
//   clk_i, rst_i            - clock, asynchronous active-high reset
//   s_axis_*                - ingress stream (header beat, then payload)
//   aw_*, w_*, b_*          - AXI4 master write channels
//   busy_o                  - FSM not idle
//   done_o                  - one-cycle pulse after the last burst response
//   err_o / err_clr_i       - sticky header/framing/response error and its clear
module meshed_network_data_writer
    import meshed_network_pkg::*;
#(
    parameter int unsigned AddrWidth     = 48,
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned IdWidth       = 4,
    parameter int unsigned AxiId         = 0,
    parameter int unsigned MaxBurstBeats = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   s_axis_tvalid_i,
    output logic                   s_axis_tready_o,
    input  logic [DataWidth-1:0]   s_axis_tdata_i,
    input  logic                   s_axis_tlast_i,
    output logic [IdWidth-1:0]     aw_id_o,
    output logic [AddrWidth-1:0]   aw_addr_o,
    output logic [7:0]             aw_len_o,
    output logic [2:0]             aw_size_o,
    output logic [1:0]             aw_burst_o,
    output logic                   aw_valid_o,
    input  logic                   aw_ready_i,
    output logic [DataWidth-1:0]   w_data_o,
    output logic [DataWidth/8-1:0] w_strb_o,
    output logic                   w_last_o,
    output logic                   w_valid_o,
    input  logic                   w_ready_i,
    input  logic [1:0]             b_resp_i,
    input  logic                   b_valid_i,
    output logic                   b_ready_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    input  logic                   err_clr_i
);

    wr_state_e              state_q, state_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [HdrLenWidth-1:0] rem_q, rem_d;
    logic [BurstWidth-1:0]  burst_q, burst_d;
    logic [BurstWidth-1:0]  cnt_q, cnt_d;
    logic                   drain_q, drain_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic [BurstWidth-1:0]  split_beats;
    logic [AddrWidth-1:0]   hdr_addr;
    logic [HdrLenWidth-1:0] hdr_len;
    logic                   hdr_ok;
    logic                   burst_last;
    logic                   pkt_last;
    logic                   tready;
    logic                   err_set;

    meshed_network_burst_splitter #(
        .MaxBurstBeats(MaxBurstBeats)
    ) u_splitter (
        .page_off_i       (addr_q[11:0]),
        .beats_remaining_i(rem_q),
        .burst_beats_o    (split_beats)
    );

    assign hdr_addr = s_axis_tdata_i[HdrAddrLsb +: AddrWidth];
    assign hdr_len  = s_axis_tdata_i[HdrLenLsb +: HdrLenWidth];
    assign hdr_ok   = (hdr_addr[2:0] == 3'd0) && (hdr_len != '0) && (hdr_len[2:0] == 3'd0);

    assign burst_last = (cnt_q == burst_q - BurstWidth'(1));
    // Last beat of the whole packet: last beat of a burst that consumes all remaining beats
    assign pkt_last   = burst_last && (rem_q == HdrLenWidth'(burst_q));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        burst_d    = burst_q;
        cnt_d      = cnt_q;
        drain_d    = drain_q;
        done_d     = 1'b0;
        err_set    = 1'b0;
        tready     = 1'b0;
        aw_valid_o = 1'b0;
        w_valid_o  = 1'b0;
        w_last_o   = 1'b0;
        b_ready_o  = 1'b0;

        case (state_q)
            StIdle: begin
                tready = 1'b1;
                if (s_axis_tvalid_i) begin
                    if (hdr_ok) begin
                        addr_d  = hdr_addr;
                        rem_d   = hdr_len >> 3;
                        drain_d = 1'b0;
                        state_d = StAw;
                    end else begin
                        err_set = 1'b1;
                        state_d = s_axis_tlast_i ? StIdle : StDrain;
                    end
                end
            end
            StAw: begin
                aw_valid_o = 1'b1;
                if (aw_ready_i) begin
                    burst_d = split_beats;
                    cnt_d   = '0;
                    state_d = StW;
                end
            end
            StW: begin
                w_valid_o = s_axis_tvalid_i;
                tready    = w_ready_i;
                w_last_o  = burst_last;
                if (s_axis_tvalid_i && w_ready_i) begin
                    cnt_d = cnt_q + BurstWidth'(1);
                    if (s_axis_tlast_i && !pkt_last) begin
                        err_set = 1'b1;
                    end
                    if (burst_last) begin
                        addr_d  = addr_q + (AddrWidth'(burst_q) << 3);
                        rem_d   = rem_q - HdrLenWidth'(burst_q);
                        state_d = StB;
                        // Length ran out before tlast: discard the rest once the burst retires
                        if (pkt_last && !s_axis_tlast_i) begin
                            err_set = 1'b1;
                            drain_d = 1'b1;
                        end
                    end
                end
            end
            StB: begin
                b_ready_o = 1'b1;
                if (b_valid_i) begin
                    if (b_resp_i != 2'b00) begin
                        err_set = 1'b1;
                    end
                    if (rem_q != '0) begin
                        state_d = StAw;
                    end else begin
                        done_d  = 1'b1;
                        state_d = drain_q ? StDrain : StIdle;
                    end
                end
            end
            StDrain: begin
                tready = 1'b1;
                if (s_axis_tvalid_i && s_axis_tlast_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        err_d = err_set ? 1'b1 : (err_clr_i ? 1'b0 : err_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            rem_q   <= '0;
            burst_q <= '0;
            cnt_q   <= '0;
            drain_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Gate ready with reset so the stream sees no acceptance while reset is held
    assign s_axis_tready_o = tready & ~rst_i;
    assign w_data_o        = s_axis_tdata_i;
    assign w_strb_o        = '1;
    assign aw_id_o         = IdWidth'(AxiId);
    assign aw_addr_o       = addr_q;
    assign aw_len_o        = 8'(split_beats - BurstWidth'(1));
    assign aw_size_o       = 3'd3;
    assign aw_burst_o      = 2'b01;
    assign busy_o          = (state_q != StIdle);
    assign done_o          = done_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_meshed_network_data_writer.sv
module tb_meshed_network_data_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tvalid = 1'b0;
    logic        tready;
    logic [63:0] tdata = '0;
    logic        tlast = 1'b0;
    logic [3:0]  aw_id;
    logic [47:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic        aw_valid;
    logic        aw_ready = 1'b1;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        w_last;
    logic        w_valid;
    logic        w_ready = 1'b1;
    logic [1:0]  b_resp = 2'b00;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic        err_clr = 1'b0;

    int checks = 0;
    int failures = 0;

    // Responder configuration, written only by the stimulus process
    logic stall = 1'b0;
    int   slverr_idx = -1;

    // Observations, written only by the responder process
    logic [47:0] aw_addr_log[$];
    logic [7:0]  aw_len_log[$];
    logic [63:0] w_data_log[$];
    logic        w_last_log[$];
    int          b_pending = 0;
    int          b_count = 0;
    int          done_cycles = 0;

    always #5 clk = ~clk;

    meshed_network_data_writer dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .s_axis_tvalid_i(tvalid),
        .s_axis_tready_o(tready),
        .s_axis_tdata_i (tdata),
        .s_axis_tlast_i (tlast),
        .aw_id_o        (aw_id),
        .aw_addr_o      (aw_addr),
        .aw_len_o       (aw_len),
        .aw_size_o      (aw_size),
        .aw_burst_o     (aw_burst),
        .aw_valid_o     (aw_valid),
        .aw_ready_i     (aw_ready),
        .w_data_o       (w_data),
        .w_strb_o       (w_strb),
        .w_last_o       (w_last),
        .w_valid_o      (w_valid),
        .w_ready_i      (w_ready),
        .b_resp_i       (b_resp),
        .b_valid_i      (b_valid),
        .b_ready_o      (b_ready),
        .busy_o         (busy),
        .done_o         (done),
        .err_o          (err),
        .err_clr_i      (err_clr)
    );

    // AXI slave model: logs handshakes at the edge, updates its drives 1 ns later
    always @(posedge clk) begin
        if (rst) begin
            b_pending = 0;
        end else begin
            if (aw_valid && aw_ready) begin
                aw_addr_log.push_back(aw_addr);
                aw_len_log.push_back(aw_len);
            end
            if (w_valid && w_ready) begin
                w_data_log.push_back(w_data);
                w_last_log.push_back(w_last);
                if (w_last) b_pending++;
            end
            if (b_valid && b_ready) begin
                b_pending--;
                b_count++;
            end
            if (done) done_cycles++;
        end
        #1;
        aw_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        w_ready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        b_valid  = (b_pending > 0) && !rst;
        b_resp   = (b_count == slverr_idx) ? 2'b10 : 2'b00;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is accepted
    task automatic send(input logic [63:0] d, input logic l);
        int  n;
        logic hs;
        if (stall && ($urandom_range(0, 2) == 0)) begin
            tvalid = 1'b0;
            @(posedge clk);
            #1;
        end
        tvalid = 1'b1;
        tdata  = d;
        tlast  = l;
        n = 0;
        forever begin
            @(negedge clk);
            hs = tready;
            @(posedge clk);
            #1;
            if (hs) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", 64'(n), 64'd0);
                break;
            end
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic header(input logic [47:0] a, input logic [15:0] len, input logic l);
        send({len, a}, l);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            n++;
            if (n > 2000) begin
                chk(tag, 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int aw0, w0, d0, bad, lasts;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_tready", 64'(tready), 64'd0);
        chk("rst_aw_valid", 64'(aw_valid), 64'd0);
        chk("rst_w_valid", 64'(w_valid), 64'd0);
        chk("rst_b_ready", 64'(b_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_tready", 64'(tready), 64'd1);
        @(posedge clk);
        #1;

        // Single 8-beat burst at 0x1000
        aw0 = aw_addr_log.size(); w0 = w_data_log.size(); d0 = done_cycles;
        header(48'h1000, 16'd64, 1'b0);
        for (int i = 0; i < 8; i++) send(64'hA0 + 64'(i), i == 7);
        wait_done("t1_done_timeout");
        idle(3);
        chk("t1_aw_count", 64'(aw_addr_log.size() - aw0), 64'd1);
        chk("t1_aw_addr", 64'(aw_addr_log[aw0]), 64'h1000);
        chk("t1_aw_len", 64'(aw_len_log[aw0]), 64'd7);
        chk("t1_w_count", 64'(w_data_log.size() - w0), 64'd8);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (w_data_log[w0 + i] !== 64'hA0 + 64'(i)) bad++;
            if (w_last_log[w0 + i] !== (i == 7)) bad++;
        end
        chk("t1_w_data_last", 64'(bad), 64'd0);
        chk("t1_done_pulses", 64'(done_cycles - d0), 64'd1);
        chk("t1_err", 64'(err), 64'd0);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_const_size", 64'(aw_size), 64'd3);
        chk("t1_const_burst", 64'(aw_burst), 64'd1);
        chk("t1_const_strb", 64'(w_strb), 64'hFF);
        chk("t1_const_id", 64'(aw_id), 64'd0);

        // 4 KiB boundary split: 0x0FF0, 32 bytes
        aw0 = aw_addr_log.size(); w0 = w_data_log.size();
        header(48'h0FF0, 16'd32, 1'b0);
        for (int i = 0; i < 4; i++) send(64'hB0 + 64'(i), i == 3);
        wait_done("t2_done_timeout");
        chk("t2_aw_count", 64'(aw_addr_log.size() - aw0), 64'd2);
        chk("t2_aw0_addr", 64'(aw_addr_log[aw0]), 64'h0FF0);
        chk("t2_aw0_len", 64'(aw_len_log[aw0]), 64'd1);
        chk("t2_aw1_addr", 64'(aw_addr_log[aw0 + 1]), 64'h1000);
        chk("t2_aw1_len", 64'(aw_len_log[aw0 + 1]), 64'd1);
        chk("t2_w_last_pattern", 64'({w_last_log[w0], w_last_log[w0 + 1],
                                      w_last_log[w0 + 2], w_last_log[w0 + 3]}), 64'b0101);
        chk("t2_err", 64'(err), 64'd0);

        // MaxBurstBeats split: 4096 bytes at 0
        aw0 = aw_addr_log.size(); w0 = w_data_log.size();
        header(48'h0, 16'd4096, 1'b0);
        for (int i = 0; i < 512; i++) send(64'(i), i == 511);
        wait_done("t3_done_timeout");
        chk("t3_aw_count", 64'(aw_addr_log.size() - aw0), 64'd2);
        chk("t3_aw0_addr", 64'(aw_addr_log[aw0]), 64'h0);
        chk("t3_aw0_len", 64'(aw_len_log[aw0]), 64'd255);
        chk("t3_aw1_addr", 64'(aw_addr_log[aw0 + 1]), 64'h800);
        chk("t3_aw1_len", 64'(aw_len_log[aw0 + 1]), 64'd255);
        bad = 0; lasts = 0;
        for (int i = 0; i < 512; i++) begin
            if (w_data_log[w0 + i] !== 64'(i)) bad++;
            if (w_last_log[w0 + i]) lasts++;
        end
        chk("t3_w_data", 64'(bad), 64'd0);
        chk("t3_w_last_count", 64'(lasts), 64'd2);
        chk("t3_w_last_pos", 64'({w_last_log[w0 + 255], w_last_log[w0 + 511]}), 64'b11);

        // Invalid header (len 12): drained, no AW, sticky err then clear
        aw0 = aw_addr_log.size();
        header(48'h2000, 16'd12, 1'b0);
        for (int i = 0; i < 3; i++) send(64'hC0 + 64'(i), i == 2);
        idle(2);
        @(negedge clk);
        chk("t4_aw_count", 64'(aw_addr_log.size() - aw0), 64'd0);
        chk("t4_err", 64'(err), 64'd1);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_tready", 64'(tready), 64'd1);
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        @(negedge clk);
        chk("t4_err_cleared", 64'(err), 64'd0);
        @(posedge clk);
        #1;

        // Stalls everywhere, SLVERR on the second burst
        stall = 1'b1;
        slverr_idx = b_count + 1;
        aw0 = aw_addr_log.size(); w0 = w_data_log.size(); d0 = done_cycles;
        header(48'h0FF0, 16'd32, 1'b0);
        for (int i = 0; i < 4; i++) send(64'hD0 + 64'(i), i == 3);
        wait_done("t5_done_timeout");
        idle(2);
        stall = 1'b0;
        chk("t5_aw_count", 64'(aw_addr_log.size() - aw0), 64'd2);
        chk("t5_aw1_addr", 64'(aw_addr_log[aw0 + 1]), 64'h1000);
        bad = 0;
        for (int i = 0; i < 4; i++) if (w_data_log[w0 + i] !== 64'hD0 + 64'(i)) bad++;
        chk("t5_w_order", 64'(bad), 64'd0);
        chk("t5_err", 64'(err), 64'd1);
        chk("t5_done_pulses", 64'(done_cycles - d0), 64'd1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        idle(2);

        // Reset in the middle of the W phase
        header(48'h3000, 16'd64, 1'b0);
        for (int i = 0; i < 3; i++) send(64'hE0 + 64'(i), 1'b0);
        tvalid = 1'b1;
        tdata  = 64'hE3;
        #1;
        chk("t6_w_valid_before", 64'(w_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_w_valid", 64'(w_valid), 64'd0);
        chk("t6_rst_tready", 64'(tready), 64'd0);
        chk("t6_rst_aw_valid", 64'(aw_valid), 64'd0);
        chk("t6_rst_b_ready", 64'(b_ready), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        tvalid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
        aw0 = aw_addr_log.size(); w0 = w_data_log.size(); d0 = done_cycles;
        header(48'h4000, 16'd16, 1'b0);
        send(64'hF0, 1'b0);
        send(64'hF1, 1'b1);
        wait_done("t6_done_timeout");
        chk("t6_aw_addr", 64'(aw_addr_log[aw0]), 64'h4000);
        chk("t6_aw_len", 64'(aw_len_log[aw0]), 64'd1);
        chk("t6_w_data", {w_data_log[w0][31:0], w_data_log[w0 + 1][31:0]}, 64'h000000F0_000000F1);
        chk("t6_done_pulses", 64'(done_cycles - d0), 64'd1);
        chk("t6_err", 64'(err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
